// File: rtl/mem_arbiter.sv
// mem_arbiter: merges an instruction and a data valid/ready requester onto one registered memory bus.
// Optional MEM_ARBITER_RR_EN selects round-robin on conflicts; default build gives data fixed priority.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_valid,
  input  logic                    i_instr,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_wstrb,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  output logic                    i_ready,
  input  logic                    d_valid,
  input  logic                    d_instr,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  input  logic [DATA_WIDTH/8-1:0] d_wstrb,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    d_ready,
  output logic                    m_valid,
  output logic                    m_instr,
  output logic [ADDR_WIDTH-1:0]   m_addr,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic                    m_ready,
  output logic [1:0]              grant
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    m_valid_q, m_valid_d;
  logic                    m_instr_q, m_instr_d;
  logic [ADDR_WIDTH-1:0]   m_addr_q, m_addr_d;
  logic [DATA_WIDTH-1:0]   m_wdata_q, m_wdata_d;
  logic [STRB_WIDTH-1:0]   m_wstrb_q, m_wstrb_d;
  logic                    pick_d;

`ifdef MEM_ARBITER_RR_EN
  // High when data won the most recent contended arbitration.
  logic last_d_q, last_d_d;
  assign pick_d = d_valid & (~i_valid | ~last_d_q);
`else
  assign pick_d = d_valid;
`endif

  always_comb begin
    state_d   = state_q;
    m_valid_d = m_valid_q;
    m_instr_d = m_instr_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_wstrb_d = m_wstrb_q;
`ifdef MEM_ARBITER_RR_EN
    last_d_d  = last_d_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_valid | d_valid) begin
          m_valid_d = 1'b1;
          if (pick_d) begin
            state_d   = DBUSY;
            m_instr_d = d_instr;
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
            m_wstrb_d = d_wstrb;
          end else begin
            state_d   = IBUSY;
            m_instr_d = i_instr;
            m_addr_d  = i_addr;
            m_wdata_d = i_wdata;
            m_wstrb_d = i_wstrb;
          end
`ifdef MEM_ARBITER_RR_EN
          if (i_valid & d_valid) last_d_d = pick_d;
`endif
        end
      end
      IBUSY, DBUSY: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d   = IDLE;
        m_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      m_valid_q <= 1'b0;
      m_instr_q <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_wstrb_q <= '0;
    end else begin
      state_q   <= state_d;
      m_valid_q <= m_valid_d;
      m_instr_q <= m_instr_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_wstrb_q <= m_wstrb_d;
    end
  end

`ifdef MEM_ARBITER_RR_EN
  // Reset to "instruction won last" so the first conflict goes to data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) last_d_q <= 1'b0;
    else      last_d_q <= last_d_d;
  end
`endif

  assign m_valid = m_valid_q;
  assign m_instr = m_instr_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign m_wstrb = m_wstrb_q;

  // Only the current owner ever sees a completion pulse.
  assign i_ready = m_ready & (state_q == IBUSY);
  assign d_ready = m_ready & (state_q == DBUSY);
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;
  assign grant   = {state_q == DBUSY, state_q == IBUSY};

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus queues expected completions and probes,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, i_instr, d_valid, d_instr;
  logic [31:0] i_addr, i_wdata, d_addr, d_wdata;
  logic [3:0]  i_wstrb, d_wstrb;
  logic [31:0] i_rdata, d_rdata;
  logic        i_ready, d_ready;
  logic        m_valid, m_instr;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wstrb;
  logic [31:0] m_rdata;
  logic        m_ready;
  logic [1:0]  grant;

  int checks = 0;
  int failures = 0;
  bit done = 1'b0;

`ifdef MEM_ARBITER_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic        is_d;
    logic [31:0] rdata;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        instr;
  } txn_t;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } probe_t;

  txn_t   exp_q[$];
  probe_t probe_q[$];

  localparam int S_GRANT = 0, S_MVALID = 1, S_MADDR = 2, S_MWDATA = 3, S_MWSTRB = 4,
                 S_MINSTR = 5, S_IREADY = 6, S_DREADY = 7, S_IRDATA = 8, S_DRDATA = 9;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_instr(i_instr), .i_addr(i_addr), .i_wdata(i_wdata),
    .i_wstrb(i_wstrb), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_valid(d_valid), .d_instr(d_instr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wstrb(d_wstrb), .d_rdata(d_rdata), .d_ready(d_ready),
    .m_valid(m_valid), .m_instr(m_instr), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_rdata(m_rdata), .m_ready(m_ready), .grant(grant)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] sig(int sel);
    case (sel)
      S_GRANT:  return {30'd0, grant};
      S_MVALID: return {31'd0, m_valid};
      S_MADDR:  return m_addr;
      S_MWDATA: return m_wdata;
      S_MWSTRB: return {28'd0, m_wstrb};
      S_MINSTR: return {31'd0, m_instr};
      S_IREADY: return {31'd0, i_ready};
      S_DREADY: return {31'd0, d_ready};
      S_IRDATA: return i_rdata;
      S_DRDATA: return d_rdata;
      default:  return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Monitor: sole owner of the counters.
  always @(negedge clk) begin : monitor
    probe_t p;
    txn_t   t;
    while (probe_q.size() > 0) begin
      p = probe_q.pop_front();
      check(p.name, sig(p.sel), p.exp);
    end
    if (i_ready || d_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ready", {30'd0, d_ready, i_ready}, 32'd0);
      end else begin
        t = exp_q.pop_front();
        $display("TXN port=%s addr=0x%08h wdata=0x%08h wstrb=0x%h instr=%0d rdata=0x%08h",
                 d_ready ? "D" : "I", m_addr, m_wdata, m_wstrb, m_instr, m_rdata);
        check("ready_port", {30'd0, d_ready, i_ready}, t.is_d ? 32'd2 : 32'd1);
        check("rdata", t.is_d ? d_rdata : i_rdata, t.rdata);
        check("txn_m_addr", m_addr, t.addr);
        check("txn_m_wdata", m_wdata, t.wdata);
        check("txn_m_wstrb", {28'd0, m_wstrb}, {28'd0, t.wstrb});
        check("txn_m_instr", {31'd0, m_instr}, {31'd0, t.instr});
      end
    end
    if (done) begin
      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probe(string name, int sel, logic [31:0] exp);
    probe_t p;
    p.name = name;
    p.sel  = sel;
    p.exp  = exp;
    probe_q.push_back(p);
  endtask

  task automatic expect_txn(logic is_d, logic [31:0] rd, logic [31:0] addr,
                            logic [31:0] wdata, logic [3:0] wstrb, logic instr);
    txn_t t;
    t.is_d = is_d; t.rdata = rd; t.addr = addr;
    t.wdata = wdata; t.wstrb = wstrb; t.instr = instr;
    exp_q.push_back(t);
  endtask

  task automatic wait_mvalid();
    int n = 0;
    while (!m_valid && n < 50) begin
      tick();
      n++;
    end
    if (!m_valid) probe("mvalid_timeout", S_MVALID, 32'd1);
  endtask

  // Memory side: wait for a request, stall wait_cyc cycles, then one-cycle m_ready.
  task automatic respond(int wait_cyc, logic [31:0] rd);
    wait_mvalid();
    repeat (wait_cyc) tick();
    m_ready = 1'b1;
    m_rdata = rd;
    tick();
    m_ready = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic is_d;
    rst = 1'b0;
    i_valid = 0; i_instr = 0; i_addr = 0; i_wdata = 0; i_wstrb = 0;
    d_valid = 0; d_instr = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0;
    m_ready = 0; m_rdata = 32'hA5A5_5A5A;

    // Reset state
    tick();
    probe("rst_grant", S_GRANT, 32'd0);
    probe("rst_m_valid", S_MVALID, 32'd0);
    probe("rst_m_instr", S_MINSTR, 32'd0);
    probe("rst_m_addr", S_MADDR, 32'd0);
    probe("rst_m_wdata", S_MWDATA, 32'd0);
    probe("rst_m_wstrb", S_MWSTRB, 32'd0);
    probe("rst_i_ready", S_IREADY, 32'd0);
    probe("rst_d_ready", S_DREADY, 32'd0);
    probe("rst_i_rdata", S_IRDATA, 32'hA5A5_5A5A);
    probe("rst_d_rdata", S_DRDATA, 32'hA5A5_5A5A);
    tick();
    rst = 1'b1;
    tick();

    // Single fetch, memory answers two cycles after m_valid
    i_valid = 1; i_instr = 1; i_addr = 32'h100; i_wdata = 0; i_wstrb = 0;
    expect_txn(1'b0, 32'h13, 32'h100, 32'h0, 4'h0, 1'b1);
    wait_mvalid();
    probe("fetch_grant", S_GRANT, 32'd1);
    probe("fetch_m_addr", S_MADDR, 32'h100);
    probe("fetch_m_wstrb", S_MWSTRB, 32'd0);
    probe("fetch_d_ready", S_DREADY, 32'd0);
    respond(2, 32'h13);
    i_valid = 0;
    probe("fetch_done_m_valid", S_MVALID, 32'd0);
    probe("fetch_done_grant", S_GRANT, 32'd0);
    probe("fetch_done_i_ready", S_IREADY, 32'd0);
    tick();

    // Store
    d_valid = 1; d_instr = 0; d_addr = 32'h2004; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF;
    expect_txn(1'b1, 32'h1111_1111, 32'h2004, 32'hDEAD_BEEF, 4'hF, 1'b0);
    wait_mvalid();
    probe("store_grant", S_GRANT, 32'd2);
    probe("store_m_wdata", S_MWDATA, 32'hDEAD_BEEF);
    probe("store_m_wstrb", S_MWSTRB, 32'hF);
    respond(1, 32'h1111_1111);
    d_valid = 0;
    probe("store_done_m_valid", S_MVALID, 32'd0);
    tick();

    // Conflict: both held for four zero-wait transactions
    i_valid = 1; i_instr = 1; i_addr = 32'h300; i_wdata = 0; i_wstrb = 0;
    d_valid = 1; d_instr = 0; d_addr = 32'h400; d_wdata = 0; d_wstrb = 0;
    for (int k = 0; k < 4; k++) begin
      is_d = RR ? ((k % 2) == 0) : 1'b1;
      expect_txn(is_d, 32'hC0 + k, is_d ? 32'h400 : 32'h300, 32'h0, 4'h0, ~is_d);
      respond(0, 32'hC0 + k);
      if (k < 3) begin
        probe("b2b_gap_m_valid", S_MVALID, 32'd0);
        tick();
        probe("b2b_next_m_valid", S_MVALID, 32'd1);
      end
    end
    d_valid = 0;
    expect_txn(1'b0, 32'hC4, 32'h300, 32'h0, 4'h0, 1'b1);
    respond(0, 32'hC4);
    i_valid = 0;
    tick();

    // Payload changes after grant are ignored
    i_valid = 1; i_instr = 1; i_addr = 32'h100;
    expect_txn(1'b0, 32'h77, 32'h100, 32'h0, 4'h0, 1'b1);
    wait_mvalid();
    i_addr = 32'h200;
    tick();
    probe("hold_m_addr", S_MADDR, 32'h100);
    respond(1, 32'h77);
    i_valid = 0; i_addr = 0;
    tick();

    // Asynchronous reset while DBUSY
    d_valid = 1; d_instr = 0; d_addr = 32'h500; d_wdata = 32'h1234; d_wstrb = 4'h3;
    wait_mvalid();
    probe("pre_rst_m_valid", S_MVALID, 32'd1);
    probe("pre_rst_grant", S_GRANT, 32'd2);
    tick();
    #1;
    rst = 1'b0;
    d_valid = 0;
    m_ready = 1'b1;
    probe("async_rst_m_valid", S_MVALID, 32'd0);
    probe("async_rst_grant", S_GRANT, 32'd0);
    probe("async_rst_m_addr", S_MADDR, 32'd0);
    probe("async_rst_d_ready", S_DREADY, 32'd0);
    tick();
    m_ready = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    i_valid = 1; i_instr = 1; i_addr = 32'h600;
    expect_txn(1'b0, 32'h99, 32'h600, 32'h0, 4'h0, 1'b1);
    wait_mvalid();
    probe("post_rst_grant", S_GRANT, 32'd1);
    respond(0, 32'h99);
    i_valid = 0;
    tick();

    // Spurious m_ready in IDLE
    m_ready = 1'b1;
    m_rdata = 32'h5555_5555;
    probe("spurious_i_ready", S_IREADY, 32'd0);
    probe("spurious_d_ready", S_DREADY, 32'd0);
    probe("spurious_grant", S_GRANT, 32'd0);
    tick();
    m_ready = 1'b0;
    probe("spurious_after_m_valid", S_MVALID, 32'd0);
    probe("spurious_after_grant", S_GRANT, 32'd0);
    tick();
    tick();
    done = 1'b1;
  end

endmodule
